// File: rtl/l2_request_arbiter.sv
// Round-robin merge of per-core L1 request streams onto the single registered L2 request port.
// Optional L2_ARB_SKID_EN macro widens the output store from one register to a two-entry FIFO.
package l2_request_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [1:0]  req_type;
    logic [31:0] addr;
    logic [15:0] tag;
  } l2req_packet_t;
endpackage

module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic          [NUM_REQUESTERS-1:0]  req_valid,
  input  l2req_packet_t [NUM_REQUESTERS-1:0]  req_packet,
  output logic          [NUM_REQUESTERS-1:0]  req_ack,
  input  logic                                l2req_ready,
  output l2req_packet_t                       l2req_packet,
  output logic                                pc_event_l2_stall
);

`ifdef L2_ARB_SKID_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned PTR_W = 1;
  // Two slots so the 1-bit pointer indexes cleanly; slot 1 stays idle when DEPTH is 1.
  localparam int unsigned SLOTS = 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned RR_W  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  l2req_packet_t    mem_q [SLOTS];
  logic [PTR_W-1:0] head_q, head_d, wr_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RR_W-1:0]  rr_q, rr_d, grant_idx;
  logic             out_valid, drain, can_accept, found, grant;
  int unsigned      idx, wr_sum;

  assign out_valid  = (count_q != '0);
  assign drain      = out_valid && l2req_ready;
  // A drain this cycle frees its slot for a same-cycle grant.
  assign can_accept = (count_q < CNT_W'(DEPTH)) || drain;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQUESTERS;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
  end

  assign grant = found && can_accept && !reset;

  always_comb begin
    req_ack = '0;
    if (grant) req_ack[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (grant_idx == RR_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    head_d = head_q;
    if (drain) head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
  end

  // Tail slot; at full with a drain this lands on the departing head slot.
  always_comb begin
    wr_sum = 32'(head_q) + 32'(count_q);
    if (wr_sum >= DEPTH) wr_sum = wr_sum - DEPTH;
    wr_idx = PTR_W'(wr_sum);
  end

  assign count_d = count_q + CNT_W'(grant) - CNT_W'(drain);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      if (grant) mem_q[wr_idx] <= req_packet[grant_idx];
    end
  end

  always_comb begin
    l2req_packet       = mem_q[head_q];
    l2req_packet.valid = out_valid;
  end

  assign pc_event_l2_stall = out_valid && !l2req_ready;

  a_ack_needs_valid : assert property (@(posedge clk) disable iff (reset)
    (req_ack & ~req_valid) == '0);
  a_ack_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(req_ack));
  a_count_max : assert property (@(posedge clk) disable iff (reset) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: directed vector table, corner-case sequences and
// a randomized run checked against a queue-based reference model.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

`ifdef L2_ARB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic          [2:0]       req_valid;
  l2req_packet_t [2:0]       req_packet;
  logic          [2:0]       req_ack;
  logic                      l2req_ready;
  l2req_packet_t             l2req_packet;
  logic                      pc_event_l2_stall;

  l2_request_arbiter #(.NUM_REQUESTERS(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_packet       (req_packet),
    .req_ack          (req_ack),
    .l2req_ready      (l2req_ready),
    .l2req_packet     (l2req_packet),
    .pc_event_l2_stall(pc_event_l2_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rv;
    logic       rdy;
    logic [2:0] ack;
    logic       vld;
  } vec_t;

  int            tests = 0;
  int            fails = 0;
  int            tag_ctr = 0;
  l2req_packet_t mq[$];
  int            rr;
  l2req_packet_t pend[3];
  logic [2:0]    last_eack;
  logic [2:0]    act_ack;
  logic          act_stall;
  l2req_packet_t act_pkt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic l2req_packet_t rand_pkt();
    l2req_packet_t p;
    p.valid    = 1'($urandom);
    p.req_type = 2'($urandom);
    p.addr     = $urandom;
    p.tag      = 16'(tag_ctr);
    tag_ctr    = tag_ctr + 1;
    return p;
  endfunction

  // First requester at or after 'start' (mod 3) with a pending request, else -1.
  function automatic int pick(input logic [2:0] rv, input int start);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (start + k) % 3;
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    rr = 0;
    for (int i = 0; i < 3; i++) pend[i] = rand_pkt();
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
  task automatic step(input logic [2:0] rv, input logic rdy);
    int   g;
    logic can, drn;
    req_valid   = rv;
    l2req_ready = rdy;
    for (int i = 0; i < 3; i++) req_packet[i] = pend[i];
    #1;
    drn       = (mq.size() > 0) && rdy;
    can       = (mq.size() < DEPTH) || drn;
    g         = pick(rv, rr);
    last_eack = (can && g >= 0) ? 3'(1 << g) : 3'b000;
    act_ack   = req_ack;
    act_stall = pc_event_l2_stall;
    act_pkt   = l2req_packet;
    check("ack", 64'(req_ack), 64'(last_eack));
    check("out_valid", 64'(l2req_packet.valid), 64'(mq.size() > 0));
    if (mq.size() > 0) check("payload", 64'(l2req_packet[49:0]), 64'(mq[0][49:0]));
    check("stall_event", 64'(pc_event_l2_stall), 64'((mq.size() > 0) && !rdy));
    @(posedge clk);
    if (drn) void'(mq.pop_front());
    if (last_eack != 3'b000) begin
      mq.push_back(pend[g]);
      rr      = (g + 1) % 3;
      pend[g] = rand_pkt();
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = 3'b111;
    for (int c = 0; c < n; c++) begin
      #1;
      check("rst_ack", 64'(req_ack), 64'(0));
      check("rst_valid", 64'(l2req_packet.valid), 64'(0));
      @(negedge clk);
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[13];
    logic [2:0] want;
    int         acks, stalls;
    l2req_packet_t snap;

    tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1};
    tbl[4]  = '{3'b110, 1'b1, 3'b010, 1'b1};
    tbl[5]  = '{3'b100, 1'b1, 3'b100, 1'b1};
    tbl[6]  = '{3'b000, 1'b1, 3'b000, 1'b1};
    tbl[7]  = '{3'b000, 1'b1, 3'b000, 1'b0};
    tbl[8]  = '{3'b010, 1'b1, 3'b010, 1'b0};
    tbl[9]  = '{3'b011, 1'b1, 3'b001, 1'b1};
    tbl[10] = '{3'b010, 1'b1, 3'b010, 1'b1};
    tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b1};
    tbl[12] = '{3'b000, 1'b1, 3'b000, 1'b0};

    reset       = 1'b1;
    req_valid   = 3'b111;
    l2req_ready = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) req_packet[i] = pend[i];
    @(negedge clk);
    do_reset(3);

    // Round-robin order and wrap/skip past idle ports.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rv, tbl[i].rdy);
      check("tbl_ack", 64'(act_ack), 64'(tbl[i].ack));
      check("tbl_valid", 64'(act_pkt.valid), 64'(tbl[i].vld));
    end

    // L2 stall with only the dcache requesting.
    do_reset(1);
    acks   = 0;
    stalls = 0;
    step(3'b010, 1'b0);
    acks += (act_ack != 3'b000) ? 1 : 0;
    for (int k = 0; k < 5; k++) begin
      step(3'b010, 1'b0);
      acks   += (act_ack != 3'b000) ? 1 : 0;
      stalls += act_stall ? 1 : 0;
      if (k == 0) snap = act_pkt;
      else check("stall_stable", 64'(act_pkt), 64'(snap));
    end
    check("stall_acks", 64'(acks), 64'(DEPTH));
    check("stall_cycles", 64'(stalls), 64'(5));

    // Full store drains and accepts the store buffer in the same cycle.
    step(3'b100, 1'b1);
    check("drain_grant_ack", 64'(act_ack), 64'(3'b100));
    for (int k = 0; k < DEPTH + 1; k++) step(3'b000, 1'b1);

    // Reset while packets are queued: they must never reach L2.
    for (int k = 0; k < 3; k++) step(3'b011, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(l2req_packet.valid), 64'(0));
    check("midrst_ack", 64'(req_ack), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(3'b110, 1'b0);
    check("post_rst_ack", 64'(act_ack), 64'(3'b010));
    step(3'b100, 1'b1);
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);

    // Randomized traffic; requesters hold until acked.
    want = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++)
        if (!want[i] && ($urandom_range(0, 99) < 40)) want[i] = 1'b1;
      step(want, $urandom_range(0, 99) < 65);
      want = want & ~last_eack;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
